// File: rtl/and_chain_sched.sv
// rtl/and_chain_sched.sv - round-robin scheduler folding requester operands through one shared AND unit
//
// and_gate: WIDTH-bit bitwise AND, the only AND datapath in this file.
//   a, b : operands
//   y    : a & b
//
// and_chain_sched: arbitrates NREQ requesters round-robin, latches the
// winner's NOPS operands and reduces them through a single and_gate, one
// operand per cycle, then reports the result with the requester id.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-requester request level, held until ack
//   ops       : operand j of requester i at ops[(i*NOPS+j)*WIDTH +: WIDTH]
//   ack       : one-cycle pulse to the served requester
//   res_valid : one-cycle result strobe
//   res       : reduced AND, held until the next result
//   res_id    : index of the served requester
//   busy      : high whenever a request is in flight

module and_gate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

module and_chain_sched #(
  parameter int NREQ  = 4,
  parameter int NOPS  = 3,
  parameter int WIDTH = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*NOPS*WIDTH-1:0]  ops,
  output logic [NREQ-1:0]             ack,
  output logic                        res_valid,
  output logic [WIDTH-1:0]            res,
  output logic [IDW-1:0]              res_id,
  output logic                        busy
);

  localparam int IW = $clog2(NOPS + 1);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] ops_q [NOPS];
  logic [WIDTH-1:0] ops_d [NOPS];

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] op_sel;
  logic [WIDTH-1:0] and_y;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(ptr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(ptr_q, i);
      end
    end
  end

  // Compare-based mux keeps idx width independent of the operand array depth.
  always_comb begin
    op_sel = '0;
    for (int j = 0; j < NOPS; j++) begin
      if (idx_q == IW'(j)) op_sel = ops_q[j];
    end
  end

  and_gate #(.WIDTH(WIDTH)) u_and (
    .a (acc_q),
    .b (op_sel),
    .y (and_y)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    res_id_d = res_id_q;
    res_d    = res_q;
    for (int j = 0; j < NOPS; j++) ops_d[j] = ops_q[j];

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          for (int j = 0; j < NOPS; j++) begin
            ops_d[j] = ops[(int'(gnt_idx) * NOPS + j) * WIDTH +: WIDTH];
          end
          acc_d    = ops[int'(gnt_idx) * NOPS * WIDTH +: WIDTH];
          idx_d    = IW'(1);
          res_id_d = gnt_idx;
          if (NOPS > 1) begin
            state_d = STEP;
          end else begin
            // Single operand: the result is the operand itself, no fold needed.
            state_d = DONE;
            res_d   = ops[int'(gnt_idx) * NOPS * WIDTH +: WIDTH];
          end
        end
      end
      STEP: begin
        acc_d = and_y;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NOPS - 1)) begin
          state_d = DONE;
          // res is loaded on entry to DONE so it equals acc there and then
          // holds while the next grant overwrites acc.
          res_d   = and_y;
        end
      end
      DONE: begin
        ptr_d   = wrap_idx(res_id_q, 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      res_id_q <= '0;
      res_q    <= '0;
      for (int j = 0; j < NOPS; j++) ops_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      res_id_q <= res_id_d;
      res_q    <= res_d;
      for (int j = 0; j < NOPS; j++) ops_q[j] <= ops_d[j];
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
    res       = res_q;
    res_id    = res_id_q;
    ack       = '0;
    if (state_q == DONE) ack = {{(NREQ-1){1'b0}}, 1'b1} << res_id_q;
  end

endmodule
